// File: rtl/dff2_pkg.sv
// rtl/dff2_pkg.sv - pin map, widths and reset contents for the dff2_gal macrocell array
package dff2_pkg;

    localparam int PIN_CLK = 0;
    localparam int PIN_AR  = 1;
    localparam int PIN_D   = 2;
    localparam int PIN_CE  = 3;
    localparam int PIN_OE  = 4;

    localparam int N_IN = 12;
    localparam int N_IO = 10;

    localparam logic [N_IO-1:0] RESET_VAL = '0;

endpackage

// File: rtl/dff2_cell.sv
// rtl/dff2_cell.sv - one macrocell: DFF with clock enable and async reset, tri-state pad driver
module dff2_cell #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic oe,
    input  logic d,
    output logic q,
    inout  wire  io
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_BIT;
        end else if (ce) begin
            q <= d;
        end
    end

    // The pad is output-only; the register never samples it back.
    assign io = oe ? q : 1'bz;

endmodule

// File: rtl/dff2_gal.sv
// rtl/dff2_gal.sv - 10-stage shift-register macrocell array with tri-stateable I/O pins
module dff2_gal #(
    parameter int                N_IN      = dff2_pkg::N_IN,
    parameter int                N_IO      = dff2_pkg::N_IO,
    parameter logic [N_IO-1:0]   RESET_VAL = dff2_pkg::RESET_VAL
) (
    input  logic [N_IN-1:0] I,
    inout  wire  [N_IO-1:0] IOQ,
    input  logic            VCC,
    input  logic            GND
);

    import dff2_pkg::*;

    logic [N_IO-1:0] q;

    // Spare dedicated inputs and power pins exist only for pin compatibility.
    logic unused_pins;
    assign unused_pins = ^{I[N_IN-1:PIN_OE+1], VCC, GND};

    genvar k;
    generate
        for (k = 0; k < N_IO; k++) begin : g_cell
            logic d_in;
            if (k == 0) begin : g_head
                assign d_in = I[PIN_D];
            end else begin : g_chain
                assign d_in = q[k-1];
            end

            dff2_cell #(
                .RESET_BIT (RESET_VAL[k])
            ) u_cell (
                .clk (I[PIN_CLK]),
                .rst (I[PIN_AR]),
                .ce  (I[PIN_CE]),
                .oe  (I[PIN_OE]),
                .d   (d_in),
                .q   (q[k]),
                .io  (IOQ[k])
            );
        end
    endgenerate

endmodule

// File: tb/tb_dff2_gal.sv
// tb/tb_dff2_gal.sv - self-checking bench for dff2_gal: vector table, depth sequence, random run
module tb_dff2_gal;

    logic [11:0] pins;
    wire  [9:0]  ioq;
    logic        vcc;
    logic        gnd;

    dff2_gal dut (
        .I   (pins),
        .IOQ (ioq),
        .VCC (vcc),
        .GND (gnd)
    );

    typedef struct {
        logic       clk;
        logic       ar;
        logic       d;
        logic       ce;
        logic       oe;
        logic       chk;
        logic       z;
        logic [9:0] exp;
    } vec_t;

    vec_t       vecs[$];
    int         checks;
    int         errors;
    logic [9:0] q_model;
    logic [9:0] zz;

    function automatic vec_t mk(input logic clk, ar, d, ce, oe, chk, z, input logic [9:0] e);
        vec_t v;
        v.clk = clk; v.ar = ar; v.d = d; v.ce = ce; v.oe = oe;
        v.chk = chk; v.z = z; v.exp = e;
        return v;
    endfunction

    // Reference: Q is a 10-bit number; an enabled rising edge computes (Q*2 + D) mod 1024.
    task automatic apply(input logic clk, ar, d, ce, oe, input bit xjunk);
        logic prev_clk;
        #9;
        prev_clk   = pins[0];
        pins[4:0]  = {oe, ce, d, ar, clk};
        pins[11:5] = xjunk ? 7'bx : 7'($urandom);
        if (ar)
            q_model = '0;
        else if (prev_clk === 1'b0 && clk && ce)
            q_model = 10'((q_model * 2 + 10'(d)) % 1024);
        #21;
    endtask

    task automatic check(input string name, input logic [9:0] exp);
        checks++;
        if (ioq !== exp) begin
            errors++;
            $display("FAIL %s: IOQ=%b expected=%b", name, ioq, exp);
        end
    endtask

    initial begin
        logic clk_s, ar_s, d_s, ce_s, oe_s;
        checks  = 0;
        errors  = 0;
        zz      = 'z;
        q_model = 'x;
        vcc     = 1'b1;
        gnd     = 1'b0;
        pins    = '0;

        //            clk ar d ce oe chk z  exp
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 10'h000));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 10'h001));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 10'h001));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 10'h003));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 10'h003));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 10'h001));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 10'h001));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 10'h002));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 10'h002));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 10'h000));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 10'h000));
        vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 10'h000));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 10'h000));
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 10'h001));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 10'h001));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 10'h000));
        vecs.push_back(mk(1, 0, 1, 1, 0, 1, 1, 10'h000));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 1, 10'h000));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 10'h003));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].clk, vecs[i].ar, vecs[i].d, vecs[i].ce, vecs[i].oe, (i % 5) == 3);
            if (vecs[i].chk)
                check($sformatf("vec%0d", i), vecs[i].z ? zz : vecs[i].exp);
        end

        // Fill with ones, then flush with zeros: the oldest bit must fall off Q[9].
        for (int n = 0; n < 10; n++) begin
            apply(0, 0, 1, 1, 1, 0);
            apply(1, 0, 1, 1, 1, 0);
            check($sformatf("fill%0d", n), q_model);
        end
        check("full_ones", 10'h3FF);
        for (int n = 0; n < 10; n++) begin
            apply(0, 0, 0, 1, 1, 0);
            apply(1, 0, 0, 1, 1, 0);
            check($sformatf("flush%0d", n), q_model);
        end
        check("full_zeros", 10'h000);
        apply(0, 0, 0, 1, 1, 0);

        clk_s = 1'b0; ar_s = 1'b0; d_s = 1'b0; ce_s = 1'b1; oe_s = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) < 2) begin
                clk_s = ~clk_s;
            end else begin
                ar_s = ($urandom_range(0, 15) == 0);
                d_s  = 1'($urandom);
                ce_s = ($urandom_range(0, 3) != 0);
                oe_s = ($urandom_range(0, 4) != 0);
            end
            apply(clk_s, ar_s, d_s, ce_s, oe_s, $urandom_range(0, 7) == 0);
            check($sformatf("rand%0d", n), oe_s ? q_model : zz);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
